// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - 8-digit multiplexed hex seven-segment scanner with frame-boundary snapshot.
// Optional leading-zero blanking when HEXDISP_LZB_EN is defined.
module hex_display_scanner #(
  parameter int CLK_DIV    = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] value_in,
  input  logic        hold,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [7:0]  an_n,
  output logic        frame_done
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [31:0]   snap_q, snap_d;
  logic          wrap_q, fd_q;
  logic [6:0]    seg_q, seg_d;
  logic [7:0]    an_q, an_d;
  logic          dp_q, dp_d;
  logic          tick, wrap, blank;
  logic [3:0]    nib;
  logic [6:0]    glyph;

  assign tick = (cnt_q == CW'(CLK_DIV - 1));
  assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + 1'b1;
    idx_d  = tick ? idx_q + 1'b1 : idx_q;
    snap_d = (wrap && !hold) ? value_in : snap_q;
  end

  assign nib = snap_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  end

`ifdef HEXDISP_LZB_EN
  logic [IW-1:0] msn;

  // Digit 0 is never blanked, so the search starts at nibble 1.
  always_comb begin
    msn = '0;
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (snap_q[4*i +: 4] != 4'h0) msn = IW'(i);
    end
    blank = (idx_q > msn);
  end
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    an_d  = blank ? 8'hFF : ~(8'h01 << idx_q);
    seg_d = blank ? 7'h7F : glyph;
    dp_d  = !((idx_q == IW'(4)) && !blank);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      idx_q  <= '0;
      snap_q <= '0;
      wrap_q <= 1'b0;
      fd_q   <= 1'b0;
      seg_q  <= 7'h7F;
      an_q   <= 8'hFF;
      dp_q   <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      // Delayed twice so the pulse lines up with digit 0's registered output.
      wrap_q <= wrap;
      fd_q   <= wrap_q;
      seg_q  <= seg_d;
      an_q   <= an_d;
      dp_q   <= dp_d;
    end
  end

  assign seg_n      = seg_q;
  assign an_n       = an_q;
  assign dp_n       = dp_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed self-checking bench for hex_display_scanner (CLK_DIV=4).
module tb_hex_display_scanner;

  logic        clk;
  logic        rst_n;
  logic [31:0] value_in;
  logic        hold;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [7:0]  an_n;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;
  int edges    = 0;

  logic [6:0] glyph_t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  hex_display_scanner #(.CLK_DIV(4), .NUM_DIGITS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .hold       (hold),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .an_n       (an_n),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic adv_to(input int n);
    while (edges < n) begin
      @(posedge clk);
      edges++;
    end
    @(negedge clk);
  endtask

  task automatic chk_rst(input string tag);
    n_checks++;
    assert (an_n === 8'hFF) else begin n_fail++; $error("FAIL %s an_n got %h exp FF", tag, an_n); end
    n_checks++;
    assert (seg_n === 7'h7F) else begin n_fail++; $error("FAIL %s seg_n got %h exp 7F", tag, seg_n); end
    n_checks++;
    assert (dp_n === 1'b1) else begin n_fail++; $error("FAIL %s dp_n got %b exp 1", tag, dp_n); end
    n_checks++;
    assert (frame_done === 1'b0) else begin n_fail++; $error("FAIL %s frame_done got %b exp 0", tag, frame_done); end
  endtask

  task automatic chk(input string tag, input int digit, input logic [31:0] snap, input logic fd);
    logic [31:0] s;
    logic [3:0]  nib;
    logic        blanked;
    logic [7:0]  e_an;
    logic        e_dp;
    int          top;
    s       = snap >> (4 * digit);
    nib     = s[3:0];
    blanked = 1'b0;
`ifdef HEXDISP_LZB_EN
    top = 0;
    for (int i = 0; i < 8; i++) begin
      s = snap >> (4 * i);
      if (s[3:0] != 4'h0) top = i;
    end
    blanked = (digit > top);
`else
    top = 7;
`endif
    e_an = blanked ? 8'hFF : ~(8'h01 << digit);
    e_dp = !(digit == 4 && !blanked);
    n_checks++;
    assert (an_n === e_an) else begin n_fail++; $error("FAIL %s an_n got %h exp %h", tag, an_n, e_an); end
    if (!blanked) begin
      n_checks++;
      assert (seg_n === glyph_t[nib]) else begin n_fail++; $error("FAIL %s seg_n got %h exp %h", tag, seg_n, glyph_t[nib]); end
    end
    n_checks++;
    assert (dp_n === e_dp) else begin n_fail++; $error("FAIL %s dp_n got %b exp %b", tag, dp_n, e_dp); end
    n_checks++;
    assert (frame_done === fd) else begin n_fail++; $error("FAIL %s frame_done got %b exp %b", tag, frame_done, fd); end
  endtask

  initial begin
    rst_n    = 1'b0;
    hold     = 1'b0;
    value_in = 32'h12345678;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_rst("reset_hold");

    // Outputs after edge n show digit ((n-1)/4)%8; wraps load the snapshot at edges 32, 64, ...
    rst_n = 1'b1;
    edges = 0;
    adv_to(1);   chk("rel_d0", 0, 32'h0, 1'b0);
    adv_to(17);  chk("f0_d4", 4, 32'h0, 1'b0);
    adv_to(32);  chk("f0_d7", 7, 32'h0, 1'b0);
    adv_to(33);  chk("f1_d0_wrap", 0, 32'h12345678, 1'b1);
    adv_to(34);  chk("f1_d0_pulse_end", 0, 32'h12345678, 1'b0);
    adv_to(36);  chk("f1_d0_last", 0, 32'h12345678, 1'b0);
    adv_to(37);  chk("f1_d1", 1, 32'h12345678, 1'b0);
    adv_to(49);  chk("f1_d4", 4, 32'h12345678, 1'b0);
    adv_to(61);  chk("f1_d7", 7, 32'h12345678, 1'b0);
    adv_to(65);  chk("f2_d0", 0, 32'h12345678, 1'b1);

    hold     = 1'b1;
    value_in = 32'hFFFFFFFF;
    adv_to(97);  chk("hold_f3_d0", 0, 32'h12345678, 1'b1);
    adv_to(129); chk("hold_f4_d0", 0, 32'h12345678, 1'b1);
    adv_to(145); chk("hold_f4_d4", 4, 32'h12345678, 1'b0);
    hold = 1'b0;
    adv_to(161); chk("unhold_d0", 0, 32'hFFFFFFFF, 1'b1);
    adv_to(189); chk("unhold_d7", 7, 32'hFFFFFFFF, 1'b0);

    adv_to(205);
    value_in = 32'hAAAAAAAA;
    adv_to(209); chk("midframe_d4", 4, 32'hFFFFFFFF, 1'b0);
    adv_to(221); chk("midframe_d7", 7, 32'hFFFFFFFF, 1'b0);
    adv_to(225); chk("newval_d0", 0, 32'hAAAAAAAA, 1'b1);
    adv_to(241); chk("newval_d4", 4, 32'hAAAAAAAA, 1'b0);

    adv_to(246); chk("pre_reset_d5", 5, 32'hAAAAAAAA, 1'b0);
    #2 rst_n = 1'b0;
    #1 chk_rst("async_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_rst("reset_held");
    value_in = 32'h000000A0;
    rst_n    = 1'b1;
    edges    = 0;
    adv_to(1);   chk("rst2_d0", 0, 32'h0, 1'b0);
    adv_to(17);  chk("rst2_d4", 4, 32'h0, 1'b0);
    adv_to(33);  chk("a0_d0", 0, 32'h000000A0, 1'b1);
    adv_to(37);  chk("a0_d1", 1, 32'h000000A0, 1'b0);
    adv_to(41);  chk("a0_d2", 2, 32'h000000A0, 1'b0);
    adv_to(49);  chk("a0_d4", 4, 32'h000000A0, 1'b0);
    adv_to(61);  chk("a0_d7", 7, 32'h000000A0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
